// File: rtl/mc_alu_pkg.sv
// Shared encodings for the multi-cycle ALU: alu_op, md_op and MDU states.
package mc_alu_pkg;

   // alu_op encodings
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_SLT  = 4'b0100;
   localparam logic [3:0] ALU_SLTU = 4'b0101;
   localparam logic [3:0] ALU_LUI  = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b1001;
   localparam logic [3:0] ALU_SRL  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1011;
   localparam logic [3:0] ALU_MFHI = 4'b1100;
   localparam logic [3:0] ALU_MFLO = 4'b1101;

   // md_op encodings (000 and 111 are both "no operation")
   localparam logic [2:0] MD_NONE  = 3'b000;
   localparam logic [2:0] MD_MULT  = 3'b001;
   localparam logic [2:0] MD_MULTU = 3'b010;
   localparam logic [2:0] MD_DIV   = 3'b011;
   localparam logic [2:0] MD_DIVU  = 3'b100;
   localparam logic [2:0] MD_MTHI  = 3'b101;
   localparam logic [2:0] MD_MTLO  = 3'b110;
   localparam logic [2:0] MD_NONE7 = 3'b111;

   // Multiply/divide sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } md_state_e;

   // True when md_op names a real multiply/divide/move request
   function automatic logic md_op_valid(input logic [2:0] op);
      return (op != MD_NONE) && (op != MD_NONE7);
   endfunction

endpackage

// File: rtl/mc_alu_mdu.sv
// Multiply/divide unit: latches operands, counts busy cycles, owns HI/LO.
module mc_alu_mdu
   import mc_alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   input  logic [2:0]       md_op_i,
   input  logic             md_start_i,
   output logic             busy_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W = $clog2(MAXC + 1);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic               sgn_q, sgn_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   logic [2*WIDTH-1:0] ext_a, ext_b, prod;
   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   abs_a, abs_b, dvsr, uq, ur, quo, rem;

   // Arithmetic on the latched operands; only sampled on the final busy cycle
   always_comb begin
      ext_a = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
      ext_b = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
      prod  = ext_a * ext_b;
      neg_a = sgn_q & a_q[WIDTH-1];
      neg_b = sgn_q & b_q[WIDTH-1];
      abs_a = neg_a ? -a_q : a_q;
      abs_b = neg_b ? -b_q : b_q;
      dvsr  = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
      uq    = abs_a / dvsr;
      ur    = abs_a % dvsr;
      // Magnitude division makes most-negative / -1 fall out naturally
      quo   = (neg_a ^ neg_b) ? -uq : uq;
      rem   = neg_a ? -ur : ur;
      if (b_q == '0) begin
         quo = '1;
         rem = a_q;
      end
   end

   // State, counter, operand latches and HI/LO registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Next-state: accept requests only in IDLE, retire results when count hits 1
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (md_start_i) begin
               case (md_op_i)
                  MD_MULT, MD_MULTU: begin
                     state_d = ST_MUL;
                     cnt_d   = CNT_W'(MUL_CYCLES);
                     a_d     = src_a_i;
                     b_d     = src_b_i;
                     sgn_d   = (md_op_i == MD_MULT);
                  end
                  MD_DIV, MD_DIVU: begin
                     state_d = ST_DIV;
                     cnt_d   = CNT_W'(DIV_CYCLES);
                     a_d     = src_a_i;
                     b_d     = src_b_i;
                     sgn_d   = (md_op_i == MD_DIV);
                  end
                  MD_MTHI: hi_d = src_a_i;
                  MD_MTLO: lo_d = src_a_i;
                  default: ;
               endcase
            end
         end
         ST_MUL, ST_DIV: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               if (state_q == ST_MUL) begin
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end else begin
                  hi_d = rem;
                  lo_d = quo;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy_o = (state_q != ST_IDLE);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: rtl/mc_alu.sv
// MIPS-style ALU: combinational datapath plus a multi-cycle multiply/divide unit.
module mc_alu
   import mc_alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10,
   parameter int OV_EN      = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [3:0]       alu_op,
   input  logic [2:0]       md_op,
   input  logic             md_start,
   input  logic             load,
   input  logic             store,
   output logic [WIDTH-1:0] result,
   output logic             ov,
   output logic             adel,
   output logic             ades,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int SHW = $clog2(WIDTH);

   logic signed [WIDTH:0] sum, diff;
   logic [SHW-1:0]        shamt;
   logic                  add_ovf, sub_ovf;

   mc_alu_mdu #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_mdu (
      .clk        (clk),
      .reset      (reset),
      .src_a_i    (src_a),
      .src_b_i    (src_b),
      .md_op_i    (md_op),
      .md_start_i (md_start),
      .busy_o     (busy),
      .hi_o       (hi),
      .lo_o       (lo)
   );

   // Sign-extended add/sub so the extra bit exposes signed overflow
   always_comb begin
      sum     = {src_a[WIDTH-1], src_a} + {src_b[WIDTH-1], src_b};
      diff    = {src_a[WIDTH-1], src_a} - {src_b[WIDTH-1], src_b};
      shamt   = src_a[SHW-1:0];
      add_ovf = (alu_op == ALU_ADD) & (sum[WIDTH] ^ sum[WIDTH-1]);
      sub_ovf = (alu_op == ALU_SUB) & (diff[WIDTH] ^ diff[WIDTH-1]);
   end

   // Result mux; mfhi/mflo show HI/LO even while the MDU is busy
   always_comb begin
      result = '0;
      case (alu_op)
         ALU_ADD:  result = sum[WIDTH-1:0];
         ALU_SUB:  result = diff[WIDTH-1:0];
         ALU_AND:  result = src_a & src_b;
         ALU_OR:   result = src_a | src_b;
         ALU_XOR:  result = src_a ^ src_b;
         ALU_NOR:  result = ~(src_a | src_b);
         ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
         ALU_LUI:  result = {src_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         ALU_SLL:  result = src_b << shamt;
         ALU_SRL:  result = src_b >> shamt;
         ALU_SRA:  result = $signed(src_b) >>> shamt;
         ALU_MFHI: result = hi;
         ALU_MFLO: result = lo;
         default:  result = '0;
      endcase
   end

   // Address-error flags always active; general overflow only when enabled
   always_comb begin
      adel  = load & add_ovf;
      ades  = store & add_ovf;
      ov    = (OV_EN != 0) & ~load & ~store & (add_ovf | sub_ovf);
      stall = busy & ((md_start & md_op_valid(md_op)) |
                      (alu_op == ALU_MFHI) | (alu_op == ALU_MFLO));
   end

endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_mc_alu;

   localparam int MULC = 5;
   localparam int DIVC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] src_a = '0, src_b = '0;
   logic [3:0]  alu_op = '0;
   logic [2:0]  md_op = '0;
   logic        md_start = 1'b0, load = 1'b0, store = 1'b0;

   logic [31:0] result, hi, lo;
   logic        ov, adel, ades, busy, stall;
   logic [31:0] result_v, hi_v, lo_v;
   logic        ov_v, adel_v, ades_v, busy_v, stall_v;

   logic [15:0] a16 = '0, b16 = '0;
   logic [3:0]  op16 = '0;
   logic [2:0]  md16 = '0;
   logic        st16 = 1'b0, ld16 = 1'b0, sto16 = 1'b0;
   logic [15:0] result16, hi16, lo16;
   logic        ov16, adel16, ades16, busy16, stall16;

   int checks = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   mc_alu #(.WIDTH(32), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .OV_EN(0)) dut (
      .clk(clk), .reset(reset), .src_a(src_a), .src_b(src_b), .alu_op(alu_op),
      .md_op(md_op), .md_start(md_start), .load(load), .store(store),
      .result(result), .ov(ov), .adel(adel), .ades(ades), .busy(busy),
      .stall(stall), .hi(hi), .lo(lo));

   mc_alu #(.WIDTH(32), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .OV_EN(1)) dut_ov (
      .clk(clk), .reset(reset), .src_a(src_a), .src_b(src_b), .alu_op(alu_op),
      .md_op(md_op), .md_start(md_start), .load(load), .store(store),
      .result(result_v), .ov(ov_v), .adel(adel_v), .ades(ades_v), .busy(busy_v),
      .stall(stall_v), .hi(hi_v), .lo(lo_v));

   mc_alu #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .src_a(a16), .src_b(b16), .alu_op(op16),
      .md_op(md16), .md_start(st16), .load(ld16), .store(sto16),
      .result(result16), .ov(ov16), .adel(adel16), .ades(ades16), .busy(busy16),
      .stall(stall16), .hi(hi16), .lo(lo16));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
   int          m_left = 0;

   function automatic logic [63:0] mdl_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint x, y, p;
      if (sgn) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'({32'b0, a});
         y = longint'({32'b0, b});
      end
      p = x * y;
      return 64'(p);
   endfunction

   // returns {remainder, quotient}
   function automatic logic [63:0] mdl_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint x, y, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'({32'b0, a});
         y = longint'({32'b0, b});
      end
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [31:0] mdl_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] h, input logic [31:0] l);
      longint sb;
      int sh;
      sh = int'(a % 32);
      sb = longint'($signed(b));
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd5:  return (a < b) ? 32'd1 : 32'd0;
         4'd6:  return {b[15:0], 16'h0000};
         4'd7:  return a ^ b;
         4'd8:  return ~(a | b);
         4'd9:  return 32'(64'(b) * (64'd1 << sh));
         4'd10: return 32'(64'(b) / (64'd1 << sh));
         4'd11: begin
            sb = sb >>> sh;
            return sb[31:0];
         end
         4'd12: return h;
         4'd13: return l;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic add_of(input logic [31:0] a, input logic [31:0] b);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   function automatic logic sub_of(input logic [31:0] a, input logic [31:0] b);
      longint s;
      s = longint'($signed(a)) - longint'($signed(b));
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   // Model state advance at each rising edge; async reset clears immediately
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_hi <= '0; m_lo <= '0; m_left <= 0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_hi <= m_phi;
            m_lo <= m_plo;
         end
      end else if (md_start) begin
         case (md_op)
            3'd1, 3'd2: begin
               {m_phi, m_plo} <= mdl_mul(md_op == 3'd1, src_a, src_b);
               m_left <= MULC;
            end
            3'd3, 3'd4: begin
               {m_phi, m_plo} <= mdl_div(md_op == 3'd3, src_a, src_b);
               m_left <= DIVC;
            end
            3'd5: m_hi <= src_a;
            3'd6: m_lo <= src_a;
            default: ;
         endcase
      end
   end

   // Single compare process, away from the active edge
   always @(negedge clk) begin
      logic aof, sof, mb, ms;
      #3;
      if (chk_en) begin
         aof = add_of(src_a, src_b) && (alu_op == 4'd0);
         sof = sub_of(src_a, src_b) && (alu_op == 4'd1);
         mb  = (m_left > 0);
         ms  = mb && ((md_start && md_op != 3'd0 && md_op != 3'd7) ||
                      alu_op == 4'd12 || alu_op == 4'd13);
         chk("m_result", result, mdl_res(alu_op, src_a, src_b, m_hi, m_lo));
         chk("m_busy", busy, mb);
         chk("m_stall", stall, ms);
         chk("m_hi", hi, m_hi);
         chk("m_lo", lo, m_lo);
         chk("m_ov_off", ov, 1'b0);
         chk("m_adel", adel, load && aof);
         chk("m_ades", ades, store && aof);
         chk("m_ov_on", ov_v, !load && !store && (aof || sof));
         chk("m_adel_on", adel_v, load && aof);
      end
   end

   // ---------------- stimulus ----------------
   task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] mop, input logic st, input logic ld, input logic sto);
      @(negedge clk);
      #1;
      alu_op = op; src_a = a; src_b = b; md_op = mop; md_start = st; load = ld; store = sto;
      #3;
   endtask

   task automatic idle(input logic [3:0] op);
      apply(op, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      repeat (2) @(negedge clk);
      #4;
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_busy", busy, 1'b0);
      @(negedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;

      // add overflow as address computation, then as plain add
      apply(4'd0, 32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, 1'b1, 1'b0);
      chk("lit_add_res", result, 32'h8000_0000);
      chk("lit_adel", adel, 1'b1);
      chk("lit_ov_off", ov, 1'b0);
      apply(4'd0, 32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, 1'b0, 1'b0);
      chk("lit_ov_on", ov_v, 1'b1);

      // mult -3 * 5
      apply(4'd0, 32'hFFFF_FFFD, 32'd5, 3'd1, 1'b1, 1'b0, 1'b0);
      chk("lit_mul_c0_busy", busy, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         idle(4'd0);
         chk("lit_mul_busy", busy, 1'b1);
      end
      idle(4'd0);
      chk("lit_mul_c6_busy", busy, 1'b0);
      chk("lit_mul_hi", hi, 32'hFFFF_FFFF);
      chk("lit_mul_lo", lo, 32'hFFFF_FFF1);

      // div -7 / 2
      apply(4'd0, 32'hFFFF_FFF9, 32'd2, 3'd3, 1'b1, 1'b0, 1'b0);
      repeat (DIVC) idle(4'd0);
      idle(4'd0);
      chk("lit_div_lo", lo, 32'hFFFF_FFFD);
      chk("lit_div_hi", hi, 32'hFFFF_FFFF);

      // divu 7 / 0
      apply(4'd0, 32'd7, 32'd0, 3'd4, 1'b1, 1'b0, 1'b0);
      repeat (DIVC) idle(4'd0);
      idle(4'd0);
      chk("lit_div0_lo", lo, 32'hFFFF_FFFF);
      chk("lit_div0_hi", hi, 32'd7);

      // most-negative / -1
      apply(4'd0, 32'h8000_0000, 32'hFFFF_FFFF, 3'd3, 1'b1, 1'b0, 1'b0);
      repeat (DIVC + 1) idle(4'd0);
      chk("lit_divmin_lo", lo, 32'h8000_0000);
      chk("lit_divmin_hi", hi, 32'd0);

      // mflo stall and ignored second start
      apply(4'd0, 32'd6, 32'd7, 3'd1, 1'b1, 1'b0, 1'b0);
      idle(4'd0);
      apply(4'd0, 32'd100, 32'd100, 3'd1, 1'b1, 1'b0, 1'b0);
      chk("lit_stall_start", stall, 1'b1);
      for (int c = 3; c <= 5; c++) begin
         idle(4'd13);
         chk("lit_stall_mflo", stall, 1'b1);
      end
      idle(4'd13);
      chk("lit_stall_done", stall, 1'b0);
      chk("lit_mflo_res", result, 32'd42);

      // reset in the middle of a divide, then mtlo
      apply(4'd0, 32'd100, 32'd3, 3'd3, 1'b1, 1'b0, 1'b0);
      idle(4'd0);
      idle(4'd0);
      @(negedge clk);
      #1 reset = 1'b1;
      md_start = 1'b0;
      #3;
      chk("lit_rst_busy", busy, 1'b0);
      chk("lit_rst_hi", hi, 32'd0);
      chk("lit_rst_lo", lo, 32'd0);
      @(negedge clk);
      #1 reset = 1'b0;
      alu_op = 4'd0; src_a = 32'h1234; src_b = 32'd0; md_op = 3'd6; md_start = 1'b1;
      #3;
      idle(4'd0);
      chk("lit_mtlo_lo", lo, 32'h1234);
      chk("lit_mtlo_busy", busy, 1'b0);

      // 16-bit instance
      a16 = 16'd15; b16 = 16'h8000; op16 = 4'b1011;
      #1 chk("lit16_sra", result16, 16'hFFFF);
      b16 = 16'h00AB; op16 = 4'b0110;
      #1 chk("lit16_lui", result16, 16'hAB00);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic st;
         st = ($urandom_range(0, 3) == 0);
         apply(4'($urandom_range(0, 15)), pick(), pick(), 3'($urandom_range(0, 7)), st,
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end

      chk_en = 1'b0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits, even, ≥8.
REQ-002 Parameter MUL_CYCLES, default 5: busy cycles for mult/multu, ≥1.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for div/divu, ≥1.
REQ-004 Parameter OV_EN, default 0: 1 enables arithmetic-overflow reporting on ov.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Ports src_a and src_b, input, WIDTH each: operands.
REQ-008 Port alu_op, input, 4: combinational op select.
REQ-009 Port md_op, input, 3: multiply/divide op select.
REQ-010 Port md_start, input, 1: qualifies md_op for one cycle.
REQ-011 Ports load and store, input, 1 each: flag the current add as an address computation.
REQ-012 Port result, output, WIDTH: combinational result.
REQ-013 Ports ov, adel and ades, output, 1 each: exception flags, all combinational.
REQ-014 Port busy, output, 1: multiply/divide in progress.
REQ-015 Port stall, output, 1: the current request needs HI/LO while busy.
REQ-016 Ports hi and lo, output, WIDTH each: architectural HI/LO registers.

Function
REQ-017 alu_op encodings and results:
- 0000 add; 0001 sub (both computed at WIDTH+1 bits, sign-extended; result is the low WIDTH bits).
- 0010 and; 0011 or; 0111 xor; 1000 nor.
- 0100 slt (signed); 0101 sltu (unsigned); each yields 0 or 1, zero-extended.
- 0110 lui: src_b[WIDTH/2-1:0] placed in the upper half, lower half zero.
- 1001 sll, 1010 srl, 1011 sra: shift src_b by src_a[log2(WIDTH)-1:0].
- 1100 mfhi → hi; 1101 mflo → lo.
- 1110 and 1111 → all-zero result.
REQ-018 Add overflow = (sum bit WIDTH ≠ sum bit WIDTH-1) with alu_op=0000; sub overflow is defined the same way on the difference with alu_op=0001.
REQ-019 adel = load & add-overflow; ades = store & add-overflow; both are independent of OV_EN.
REQ-020 ov = OV_EN & ~load & ~store & (add-overflow | sub-overflow); ov is constant 0 when OV_EN=0.
REQ-021 md_op encodings: 000 none; 001 mult; 010 multu; 011 div; 100 divu; 101 mthi; 110 mtlo; 111 none.
REQ-022 State machine states:
- IDLE → MUL on an accepted start of mult/multu.
- IDLE → DIV on an accepted start of div/divu.
- MUL/DIV → IDLE when the counter reaches 1.
REQ-023 A start is accepted only when md_start=1 and state=IDLE. Operands are latched on acceptance. The counter loads MUL_CYCLES or DIV_CYCLES.
REQ-024 busy=1 in MUL/DIV. It asserts the cycle after acceptance and stays high exactly MUL_CYCLES or DIV_CYCLES cycles.
REQ-025 HI/LO update on the clock edge that returns the state to IDLE:
- mult/multu: {hi,lo} = 2·WIDTH-bit product (signed or unsigned).
- div/divu: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
REQ-026 Divide by zero: lo = all-ones, hi = latched dividend; no exception.
REQ-027 Signed div of most-negative by −1: lo = most-negative, hi = 0.
REQ-028 mthi/mtlo with md_start=1 in IDLE write src_a to hi/lo at the next edge, take one cycle, and leave busy at 0.
REQ-029 Any md_start while busy is ignored; HI/LO are unaffected by the ignored request.
REQ-030 stall = busy & (md_start with md_op≠none, or alu_op ∈ {1100, 1101}). result still shows the current hi/lo.
REQ-031 stall goes to 0 in the cycle after completion. The updated HI/LO are readable in that same cycle.

Reset
REQ-032 reset=1 asynchronously forces state=IDLE, counter=0, busy=0, hi=0, lo=0, and the latched operands to 0.
REQ-033 A reset during MUL/DIV aborts the operation; HI/LO read 0 after reset.
REQ-034 Combinational outputs (result, ov, adel, ades) are not gated by reset.

Structure
REQ-035 The alu_op and md_op encodings and the state encodings SHALL be localparams in a shared package, mc_alu_pkg.
REQ-036 Multiply/divide sequencing and HI/LO SHALL live in one sub-module, mc_alu_mdu; mc_alu holds the combinational datapath and instantiates mc_alu_mdu.
REQ-037 The arithmetic for each operation MAY be computed in a single cycle and held until completion; only the busy timing is architecturally visible.

Verification
REQ-038 WIDTH=32, OV_EN=0: add 0x7FFFFFFF+1 with load=1 → result 0x80000000, adel=1, ov=0; same add with load=0 and OV_EN=1 → ov=1.
REQ-039 mult −3×5 with md_start=1 at cycle 0 → busy high for cycles 1–5; hi=0xFFFFFFFF and lo=0xFFFFFFF1 visible at cycle 6.
REQ-040 div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 → lo=0xFFFFFFFF, hi=7.
REQ-041 mflo issued at cycle 3 of a mult → stall=1 through cycle 5, then 0 at cycle 6. A second md_start at cycle 2 is ignored; the final lo equals the first product.
REQ-042 reset pulse at cycle 3 of a div → busy=0 immediately, hi=lo=0; a following mtlo 0x1234 → lo=0x1234 next cycle, busy stays 0.
REQ-043 WIDTH=16: sra 0x8000 by 15 → 0xFFFF; lui src_b=0x00AB → 0xAB00.
